// File: rtl/wb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sram_slave_pkg
//  Description : Shared definitions for the Wishbone SRAM responder:
//                FSM state encoding, bus widths and the window check helper.
//  Ports       : none (package)
//  Config      : WB_SRAM_ERR_EN (consumed by wb_sram_slave)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_sram_slave_pkg;

    localparam int unsigned WB_DW      = 32;
    localparam logic [3:0]  WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_RESP = 2'd2
    } wb_state_e;

    // True when adr lies in [base, base+span). The subtraction wraps for
    // addresses below base, which then compare as too large.
    function automatic logic addr_in_window(input logic [31:0] adr,
                                            input logic [31:0] base,
                                            input logic [32:0] span);
        logic [31:0] off;
        off = adr - base;
        return ({1'b0, off} < span);
    endfunction

endpackage : wb_sram_slave_pkg
`default_nettype wire

// File: rtl/wb_sram_array.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sram_array
//  Description : Single-port word RAM with four byte enables and a
//                registered read port (inferred memory, no reset on data).
//  Ports       : clk_i      clock
//                we_i       write strobe
//                be_i[3:0]  byte enables, [0] = bits 7:0
//                addr_i     word index
//                wdata_i    write data
//                rdata_o    word at addr_i as of the previous rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sram_array
    import wb_sram_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WB_DW-1:0] wdata_i,
    output logic [WB_DW-1:0] rdata_o
);

    logic [WB_DW-1:0] mem_q [DEPTH];
    logic [WB_DW-1:0] rdata_q;

    // Read-before-write: a read on the write cycle returns the old word;
    // the responder never consumes read data on a write.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i && be_i[k]) begin
                mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule : wb_sram_array
`default_nettype wire

// File: rtl/wb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wb_sram_slave
//  Description : Wishbone classic single-cycle responder in front of a word
//                organised on-chip SRAM. Byte-lane writes, programmable wait
//                states, one-cycle ack/err termination.
//  Ports       : clk_i, rst_n_i (async assert, active-low)
//                wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i[3:0]
//                wb_adr_i[31:0] byte address, wb_dat_i[31:0] write data
//                wb_dat_o[31:0] read data (valid while wb_ack_o)
//                wb_ack_o, wb_err_o termination pulses
//  Config      : `define WB_SRAM_ERR_EN -> out-of-window accesses terminate
//                with wb_err_o; otherwise the window aliases and every
//                request is acked.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_sram_slave
    import wb_sram_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [WB_DW-1:0] wb_dat_i,
    output logic [WB_DW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o
);

    localparam int unsigned c_AW    = $clog2(DEPTH);
    localparam logic [3:0]  c_WS_LD = 4'(WAIT_STATES);

    wb_state_e        state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic             hit_q;
    logic [3:0]       sel_q;
    logic [c_AW-1:0]  idx_q;
    logic [WB_DW-1:0] wdat_q;
    logic             ack_q;
    logic             err_q;
    logic             rd_q;

    logic             req;
    logic [c_AW-1:0]  bus_idx;
    logic             bus_hit;
    logic             resp_from_idle;
    logic             resp_from_wait;
    logic             enter_resp;
    logic             cur_hit;
    logic             cur_we;
    logic             err_term;
    logic             ram_we;
    logic [3:0]       ram_be;
    logic [c_AW-1:0]  ram_idx;
    logic [WB_DW-1:0] ram_wdata;
    logic [WB_DW-1:0] ram_rdata;

    assign req     = wb_cyc_i & wb_stb_i;
    assign bus_idx = c_AW'((wb_adr_i - BASE_ADDR) >> 2);

`ifdef WB_SRAM_ERR_EN
    assign bus_hit = addr_in_window(wb_adr_i, BASE_ADDR, 33'(DEPTH) << 2);
`else
    assign bus_hit = 1'b1;
`endif

    // A zero-wait request goes straight from IDLE to RESP on the sampling
    // edge; otherwise RESP is entered from WAIT when the counter hits 1.
    // An abort (cyc dropped) in WAIT takes priority over termination.
    assign resp_from_idle = (state_q == WB_S_IDLE) && req && (WAIT_STATES == 0);
    assign resp_from_wait = (state_q == WB_S_WAIT) && wb_cyc_i && (cnt_q == 4'd1);
    assign enter_resp     = resp_from_idle | resp_from_wait;

    assign cur_hit = resp_from_idle ? bus_hit : hit_q;
    assign cur_we  = resp_from_idle ? wb_we_i : we_q;

`ifdef WB_SRAM_ERR_EN
    assign err_term = enter_resp & ~cur_hit;
`else
    assign err_term = 1'b0;
`endif

    // The RAM sees the live bus in IDLE and the captured request otherwise,
    // so the registered read lands exactly on the edge entering RESP even
    // with zero wait states.
    assign ram_idx   = (state_q == WB_S_IDLE) ? bus_idx  : idx_q;
    assign ram_be    = (state_q == WB_S_IDLE) ? wb_sel_i : sel_q;
    assign ram_wdata = (state_q == WB_S_IDLE) ? wb_dat_i : wdat_q;
    assign ram_we    = enter_resp & cur_hit & cur_we;

    wb_sram_array #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= WB_S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            ack_q <= enter_resp & cur_hit;
            err_q <= err_term;
            rd_q  <= enter_resp & cur_hit & ~cur_we;
            case (state_q)
                WB_S_IDLE: begin
                    if (req) begin
                        we_q   <= wb_we_i;
                        hit_q  <= bus_hit;
                        sel_q  <= wb_sel_i;
                        idx_q  <= bus_idx;
                        wdat_q <= wb_dat_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= WB_S_RESP;
                        end else begin
                            state_q <= WB_S_WAIT;
                            cnt_q   <= c_WS_LD;
                        end
                    end
                end
                WB_S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= WB_S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= WB_S_RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WB_S_RESP: begin
                    state_q <= WB_S_IDLE;
                end
                default: begin
                    state_q <= WB_S_IDLE;
                end
            endcase
        end
    end

    // Read data comes straight from the RAM output register, which was
    // loaded on the edge entering RESP; the flag forces zero otherwise.
    assign wb_dat_o = rd_q ? ram_rdata : '0;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule : wb_sram_slave
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_sram_slave
//  Description : Self-checking bench for wb_sram_slave. Two instances run:
//                zero wait states at base 0 and three wait states at base
//                0x0001_0000. Directed cases plus randomized traffic are
//                compared against a byte-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sram_slave;
    import wb_sram_slave_pkg::*;

    localparam int unsigned DEPTH = 1024;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    logic [31:0] mdat [2][DEPTH];
    logic [3:0]  mval [2][DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    wb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
    );

    wb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0001_0000)) u_dut1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0001_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
    endtask

    // One bus transaction on instance d, checked against the model.
    task automatic xfer(input int d, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] v, input bit abort);
        int          n;
        bit          seen;
        int          idx;
        logic        exp_err;
        logic [31:0] off;
        logic [31:0] m;
        off = a - base_of(d);
        idx = int'((off >> 2) % DEPTH);
`ifdef WB_SRAM_ERR_EN
        exp_err = (off >= DEPTH * 4);
`else
        exp_err = 1'b0;
`endif
        @(posedge clk_i); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wdat[d] = v;
        if (abort) begin
            @(posedge clk_i); #1;
            idle_bus(d);
            seen = 0;
            repeat (ws_of(d) + 3) begin
                @(posedge clk_i); #1;
                if (ack[d] || err[d]) seen = 1;
            end
            check_eq("abort_no_term", 32'(seen), 32'd0);
            return;
        end
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk_i); #1;
            n++;
            if (ack[d] || err[d]) seen = 1;
            else begin
                // Bus changes after acceptance must not affect the transfer.
                adr[d] = $urandom; wdat[d] = $urandom; sel[d] = 4'($urandom); we[d] = 1'($urandom);
            end
        end
        check_eq("term_seen", 32'(seen), 32'd1);
        if (!seen) begin
            idle_bus(d);
            return;
        end
        check_eq("latency", 32'(n), 32'(ws_of(d) + 1));
        check_eq("ack", 32'(ack[d]), 32'(!exp_err));
        check_eq("err", 32'(err[d]), 32'(exp_err));
        if (!w && !exp_err) begin
            m = {{8{mval[d][idx][3]}}, {8{mval[d][idx][2]}}, {8{mval[d][idx][1]}}, {8{mval[d][idx][0]}}};
            if (m != 32'h0) check_eq("rdata", rdat[d] & m, mdat[d][idx] & m);
        end else begin
            check_eq("dat_zero", rdat[d], 32'h0);
        end
        idle_bus(d);
        if (w && !exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) begin
                    mdat[d][idx][8*k +: 8] = v[8*k +: 8];
                    mval[d][idx][k] = 1'b1;
                end
            end
        end
        @(posedge clk_i); #1;
        check_eq("post_ack", 32'(ack[d]), 32'd0);
        check_eq("post_err", 32'(err[d]), 32'd0);
        check_eq("post_dat", rdat[d], 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            idle_bus(d);
            for (int i = 0; i < DEPTH; i++) begin
                mdat[d][i] = 32'h0;
                mval[d][i] = 4'h0;
            end
        end
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ack", 32'(ack[d]), 32'd0);
            check_eq("rst_err", 32'(err[d]), 32'd0);
            check_eq("rst_dat", rdat[d], 32'h0);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Basic write then read, zero wait states.
        xfer(0, 1, WB_SEL_ALL, 32'h10, 32'hDEADBEEF, 0);
        xfer(0, 0, WB_SEL_ALL, 32'h10, 32'h0, 0);
        // Partial lane write over a known word.
        xfer(0, 1, WB_SEL_ALL, 32'h20, 32'h11223344, 0);
        xfer(0, 1, 4'b0101,    32'h20, 32'hAABBCCDD, 0);
        xfer(0, 0, WB_SEL_ALL, 32'h20, 32'h0, 0);
        check_eq("lane_merge_model", mdat[0][8], 32'h11BB33DD);
        // sel = 0 write acks and leaves the word alone.
        xfer(0, 1, 4'b0000,    32'h20, 32'h55555555, 0);
        xfer(0, 0, WB_SEL_ALL, 32'h20, 32'h0, 0);
        // Wait-state read.
        xfer(1, 1, WB_SEL_ALL, 32'h0001_0040, 32'h0BADCAFE, 0);
        xfer(1, 0, 4'h1,       32'h0001_0040, 32'h0, 0);
        // Abort during WAIT leaves memory unchanged.
        xfer(1, 1, WB_SEL_ALL, 32'h0001_0030, 32'h12345678, 0);
        xfer(1, 1, WB_SEL_ALL, 32'h0001_0030, 32'hFFFFFFFF, 1);
        xfer(1, 0, WB_SEL_ALL, 32'h0001_0030, 32'h0, 0);
        // One past the window: err with the macro, alias to word 0 without.
        xfer(0, 1, WB_SEL_ALL, 32'h0, 32'h01020304, 0);
        xfer(0, 1, WB_SEL_ALL, 32'h1000, 32'hCAFEF00D, 0);
        xfer(0, 0, WB_SEL_ALL, 32'h1000, 32'h0, 0);
        xfer(0, 0, WB_SEL_ALL, 32'h0, 32'h0, 0);

        // Reset in the middle of a WAIT.
        @(posedge clk_i); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h0001_0040;
        @(posedge clk_i); #3;
        rst_n_i = 1'b0;
        #1;
        check_eq("midrst_ack", 32'(ack[1]), 32'd0);
        check_eq("midrst_err", 32'(err[1]), 32'd0);
        check_eq("midrst_dat", rdat[1], 32'h0);
        idle_bus(1);
        @(posedge clk_i); #1;
        check_eq("midrst_hold_ack", 32'(ack[1]), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        xfer(1, 0, WB_SEL_ALL, 32'h0001_0040, 32'h0, 0);

        // Randomized traffic over a small word pool, with occasional
        // aliasing/out-of-window addresses and aborts on the waited instance.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 120; t++) begin
                logic [31:0] a;
                bit          ab;
                a = base_of(d) + 32'($urandom_range(0, 31)) * 4;
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 4)) * 32'h1000;
                if (d == 1 && $urandom_range(0, 15) == 0) a = base_of(d) - 32'($urandom_range(1, 8)) * 4;
                ab = (d == 1) && ($urandom_range(0, 9) == 0);
                xfer(d, 1'($urandom), 4'($urandom), a, $urandom, ab);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_sram_slave
`default_nettype wire
